// File: rtl/seg7_scan_if.sv
// Register-file to display bundle: source words and select in, digit drive out.
interface seg7_scan_if;
  logic [15:0] result;
  logic [15:0] counter;
  logic        sel;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (output result, counter, sel, input an, seg, dp);
  modport slave  (input result, counter, sel, output an, seg, dp);
endinterface

// File: rtl/seg7_scan.sv
// Four-digit multiplexed hex display with per-frame snapshot (tear-free).
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan #(
  parameter int unsigned DIV = 50000
) (
  input logic        clk,
  input logic        rst_n,
  seg7_scan_if.slave bus
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PcMax = PW'(DIV - 1);

  logic [PW-1:0] pc_q, pc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic          snap_sel_q, snap_sel_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic          wrap;
  logic [1:0]    n;
  logic [15:0]   shifted;
  logic          blank;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    tick       = (pc_q == PcMax);
    pc_d       = tick ? '0 : pc_q + PW'(1);
    n          = idx_q + 2'd1;
    idx_d      = tick ? n : idx_q;
    wrap       = tick && (idx_q == 2'd3);
    snap_d     = wrap ? (bus.sel ? bus.counter : bus.result) : snap_q;
    snap_sel_d = wrap ? bus.sel : snap_sel_q;
    // Use the next snapshot so digit 0 shows the value loaded on this same edge.
    shifted    = snap_d >> {n, 2'b00};
`ifdef SEG7_LZB_EN
    blank      = (n != 2'd0) && (shifted == 16'h0000);
`else
    blank      = 1'b0;
`endif
    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (tick) begin
      an_d  = ~(4'b0001 << n);
      seg_d = hex7(shifted[3:0]);
      dp_d  = !((n == 2'd0) && snap_sel_d);
      if (blank) begin
        an_d  = 4'hF;
        seg_d = 7'h7F;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      idx_q      <= 2'd3;
      snap_q     <= 16'h0000;
      snap_sel_q <= 1'b0;
      an_q       <= 4'hF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      pc_q       <= pc_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      snap_sel_q <= snap_sel_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: a DIV=4 instance and a DIV=2 instance.
module tb_seg7_scan;

  logic clk;
  logic rst_n4;
  logic rst_n2;
  int   checks;
  int   errors;

  seg7_scan_if bus4 ();
  seg7_scan_if bus2 ();

  seg7_scan #(.DIV(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n4),
    .bus   (bus4.slave)
  );

  seg7_scan #(.DIV(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n2),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sel on the DIV=2 instance toggles every cycle once out of reset.
  always @(negedge clk) begin
    if (!rst_n2) bus2.sel = 1'b0;
    else         bus2.sel = ~bus2.sel;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Checks one digit slot on every cycle it is held, ending one slot later.
  task automatic check_slot(input string tag, input bit d2, input logic [3:0] an_e,
                            input logic [6:0] seg_e, input logic dp_e);
    int div;
    div = d2 ? 2 : 4;
    for (int c = 0; c < div; c++) begin
      check({tag, "_an"},  16'(d2 ? bus2.an  : bus4.an),  16'(an_e));
      check({tag, "_seg"}, 16'(d2 ? bus2.seg : bus4.seg), 16'(seg_e));
      check({tag, "_dp"},  16'(d2 ? bus2.dp  : bus4.dp),  16'(dp_e));
      step(1);
    end
  endtask

  task automatic check_blank(input string tag, input bit d2);
    check({tag, "_an"},  16'(d2 ? bus2.an  : bus4.an),  16'h000F);
    check({tag, "_seg"}, 16'(d2 ? bus2.seg : bus4.seg), 16'h007F);
    check({tag, "_dp"},  16'(d2 ? bus2.dp  : bus4.dp),  16'h0001);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n4       = 1'b0;
    rst_n2       = 1'b0;
    bus4.result  = 16'h1234;
    bus4.counter = 16'hABCD;
    bus4.sel     = 1'b0;
    bus2.result  = 16'h1234;
    bus2.counter = 16'hABCD;

    step(3);
    check_blank("rst_hold", 1'b0);
    rst_n4 = 1'b1;
    step(3);
    check_blank("pre_tick", 1'b0);
    step(1);

    // Frame 1: plain scan of 1234.
    check_slot("f1_d0", 1'b0, 4'hE, 7'h19, 1'b1);
    check_slot("f1_d1", 1'b0, 4'hD, 7'h30, 1'b1);
    check_slot("f1_d2", 1'b0, 4'hB, 7'h24, 1'b1);
    check_slot("f1_d3", 1'b0, 4'h7, 7'h79, 1'b1);

    // Frame 2: input changes mid-frame must not tear.
    check_slot("f2_d0", 1'b0, 4'hE, 7'h19, 1'b1);
    bus4.result = 16'hFFFF;
    check_slot("f2_d1", 1'b0, 4'hD, 7'h30, 1'b1);
    check_slot("f2_d2", 1'b0, 4'hB, 7'h24, 1'b1);
    check_slot("f2_d3", 1'b0, 4'h7, 7'h79, 1'b1);

    // Frame 3: FFFF shown; sel flips mid-frame and is ignored here.
    check_slot("f3_d0", 1'b0, 4'hE, 7'h0E, 1'b1);
    bus4.sel = 1'b1;
    check_slot("f3_d1", 1'b0, 4'hD, 7'h0E, 1'b1);
    check_slot("f3_d2", 1'b0, 4'hB, 7'h0E, 1'b1);
    check_slot("f3_d3", 1'b0, 4'h7, 7'h0E, 1'b1);

    // Frame 4: counter view ABCD with dp on digit 0.
    check_slot("f4_d0", 1'b0, 4'hE, 7'h21, 1'b0);
    bus4.sel    = 1'b0;
    bus4.result = 16'h0005;
    check_slot("f4_d1", 1'b0, 4'hD, 7'h46, 1'b1);
    check_slot("f4_d2", 1'b0, 4'hB, 7'h03, 1'b1);
    check_slot("f4_d3", 1'b0, 4'h7, 7'h08, 1'b1);

    // Frame 5: 0005, leading zeros shown or blanked.
    check_slot("f5_d0", 1'b0, 4'hE, 7'h12, 1'b1);
    bus4.result = 16'h0000;
`ifdef SEG7_LZB_EN
    check_slot("f5_d1", 1'b0, 4'hF, 7'h7F, 1'b1);
    check_slot("f5_d2", 1'b0, 4'hF, 7'h7F, 1'b1);
    check_slot("f5_d3", 1'b0, 4'hF, 7'h7F, 1'b1);
`else
    check_slot("f5_d1", 1'b0, 4'hD, 7'h40, 1'b1);
    check_slot("f5_d2", 1'b0, 4'hB, 7'h40, 1'b1);
    check_slot("f5_d3", 1'b0, 4'h7, 7'h40, 1'b1);
`endif

    // Frame 6: zero keeps a single digit 0; then asynchronous reset mid-slot.
    check_slot("f6_d0", 1'b0, 4'hE, 7'h40, 1'b1);
`ifdef SEG7_LZB_EN
    check_slot("f6_d1", 1'b0, 4'hF, 7'h7F, 1'b1);
`else
    check_slot("f6_d1", 1'b0, 4'hD, 7'h40, 1'b1);
`endif
    #2 rst_n4 = 1'b0;
    #1 check_blank("async_rst", 1'b0);
    step(1);
    rst_n4 = 1'b1;
    step(3);
    check_blank("re_pre_tick", 1'b0);
    step(1);
    check_slot("re_d0", 1'b0, 4'hE, 7'h40, 1'b1);

    // DIV=2 instance with sel toggling every cycle; wraps always sample sel=1.
    @(negedge clk);
    #1 rst_n2 = 1'b1;
    step(1);
    check_blank("d2_pre_tick", 1'b1);
    step(1);
    for (int f = 0; f < 2; f++) begin
      check_slot("d2_d0", 1'b1, 4'hE, 7'h21, 1'b0);
      check_slot("d2_d1", 1'b1, 4'hD, 7'h46, 1'b1);
      check_slot("d2_d2", 1'b1, 4'hB, 7'h03, 1'b1);
      check_slot("d2_d3", 1'b1, 4'h7, 7'h08, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
